ws2812_frame_tx: RTL
====================

// Module: ws2812_frame_tx
// PURPOSE
//  Downstream stage of the iomem 0x04 LED-write register in the icesugar top.
//  Holds one 24-bit colour word per pixel and refreshes the whole WS2812 chain
//  continuously on one pin: every pixel, MSB first, then a low latch gap.
//  CPU writes land in the pixel store; the next frame carries them out.
// PARAMETERS
//  NUM_LEDS      7     pixels in chain (1..256)
//  T0H_CYCLES    4     clk cycles high for a 0 bit (0.33us @12MHz)
//  T1H_CYCLES    8     clk cycles high for a 1 bit (0.67us @12MHz)
//  BIT_CYCLES    15    total clk cycles per bit (1.25us @12MHz)
//  LATCH_CYCLES  3600  low cycles between frames (300us @12MHz)
//  Legal set: 0 < T0H_CYCLES < T1H_CYCLES < BIT_CYCLES; LATCH_CYCLES >= 1.
// PORTS
//  clk         in   1   system clock
//  reset       in   1   asynchronous, active-high reset
//  write       in   1   1-cycle strobe: store rgb_data at pixel led_num
//  led_num     in   8   pixel index; values >= NUM_LEDS are ignored
//  rgb_data    in   24  colour word, sent bit 23 first (software packs GRB)
//  data        out  1   serial line to the first WS2812 DIN
//  busy        out  1   1 while pixel bits are on the line, 0 during latch
//  frame_done  out  1   1-cycle pulse on the first cycle of each latch gap
// BEHAVIOUR
//  Reset (async, active-high): all pixel words=0; state=LATCH, latch count=0;
//   data=0, busy=0, frame_done=0. The first frame starts after LATCH_CYCLES.
//  States: LATCH -> HIGH -> LOW -> (HIGH | LATCH).
//   LATCH: data=0 for LATCH_CYCLES cycles. On its last cycle, load pixel 0
//    into the 24-bit shift register, bit count=23, go to HIGH.
//   HIGH: data=1 for T1H_CYCLES if the current bit is 1, else T0H_CYCLES.
//   LOW: data=0 for the remainder of BIT_CYCLES.
//    At the end of LOW, if bit count>0: shift left, decrement, go to HIGH.
//    Else if pixel<NUM_LEDS-1: load the next pixel, count=23, go to HIGH.
//    Else go to LATCH and assert frame_done for that entry cycle.
//  No idle cycles between bits or pixels: every bit is exactly BIT_CYCLES long.
//  A frame lasts NUM_LEDS*24*BIT_CYCLES + LATCH_CYCLES cycles.
//  data is registered; HIGH/LOW boundaries are exact to the cycle.
//  busy=1 in HIGH and LOW, 0 in LATCH.
//  Writes:
//   - Accepted in any state; take effect one cycle after the strobe.
//   - led_num >= NUM_LEDS: dropped, no state change.
//   - Writing the pixel currently shifting does not disturb it; the shift
//     register copy is sent and the new value goes out next frame.
//   - A write in the same cycle as that pixel's load: the load takes the
//     old word; the new word goes out next frame.
//   - Back-to-back writes every cycle are all accepted.
//  Counters are sized by $clog2 of their limits; no wrap is reachable within
//   the legal parameter set.
//  Reset mid-frame: line drops low immediately; the full latch gap runs
//   before a new frame.
// TESTING
//  (Bench params: NUM_LEDS=2, T0H=2, T1H=4, BIT=6, LATCH=10.)
//  1 Release reset, no writes -> data low 10 cycles, then 48 bits each 2 high/4
//    low; busy=1 for 288 cycles; frame_done pulses at cycle 298.
//  2 Write led 0=24'h800001 -> next frame: bit0 4 high/2 low, bits1..22 2/4,
//    bit23 4/2; pixel 1 all zeros.
//  3 Write led 1=24'hFFFFFF while pixel 1 is mid-shift -> current frame sends
//    old pixel 1; following frame sends all 1 bits.
//  4 Write led_num=2 and led_num=255 -> pixel store unchanged; stream identical
//    to the prior frame.
//  5 Assert reset mid-bit while data=1 -> data=0 the same cycle; 10 latch
//    cycles, then pixel words read as 0.
//  6 Write led 0 on its load cycle -> old word sent; the new word appears
//    exactly one frame (298 cycles) later.

Source files
------------

// File: rtl/ws2812_frame_tx.sv
`timescale 1ns/1ps
// ws2812_frame_tx
// Continuously refreshes a chain of WS2812 pixels from an internal store of
// 24-bit colour words. Each frame sends every pixel, starting with pixel 0.
// Each word is sent bit 23 first. A low latch gap follows every frame.
// CPU writes update the store at any time. A pixel's word is copied into
// the shift register when that pixel starts, so a write shows up on the line
// in the first frame that loads that pixel after the write.
//
// Ports
//   clk         system clock
//   reset       asynchronous, active-high reset
//   write       1-cycle strobe: store rgb_data at pixel led_num
//   led_num     pixel index; indices >= NUM_LEDS are dropped
//   rgb_data    colour word, bit 23 sent first
//   data        registered serial line to the first WS2812 DIN
//   busy        1 while pixel bits are on the line, 0 during the latch gap
//   frame_done  1-cycle pulse on the first cycle of each latch gap
module ws2812_frame_tx #(
    parameter int NUM_LEDS     = 7,
    parameter int T0H_CYCLES   = 4,
    parameter int T1H_CYCLES   = 8,
    parameter int BIT_CYCLES   = 15,
    parameter int LATCH_CYCLES = 3600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [7:0]  led_num,
    input  logic [23:0] rgb_data,
    output logic        data,
    output logic        busy,
    output logic        frame_done
);

    localparam int PIX_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int PH_W  = $clog2(BIT_CYCLES);
    localparam int LAT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_LEDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATCH_CYCLES - 1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(BIT_CYCLES - 1);
    localparam logic [PH_W-1:0]  T0H_LAST = PH_W'(T0H_CYCLES - 1);
    localparam logic [PH_W-1:0]  T1H_LAST = PH_W'(T1H_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LATCH = 2'd0,
        ST_HIGH  = 2'd1,
        ST_LOW   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [LAT_W-1:0]   latch_cnt_reg;
    logic [PH_W-1:0]    phase_reg;      // cycle within the current bit
    logic [4:0]         bit_cnt_reg;    // bits still to send after this one
    logic [PIX_W-1:0]   pix_idx_reg;
    logic [23:0]        shift_reg;
    logic               data_reg, data_next;
    logic               frame_done_reg, frame_done_next;

    // ---------------- pixel store ----------------
    logic               wr_hit;
    logic [23:0]        pixel_word [NUM_LEDS];
    logic [PIX_W-1:0]   load_idx;
    logic [23:0]        load_word;

    assign wr_hit = write && ({1'b0, led_num} < 9'(NUM_LEDS));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_pix
            logic [23:0] word_reg;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (wr_hit && (led_num == 8'(gi))) begin
                    word_reg <= rgb_data;
                end
            end
            assign pixel_word[gi] = word_reg;
        end
    endgenerate

    // Leaving LATCH always starts pixel 0; otherwise a pixel load is the next one.
    assign load_idx  = (state_reg == ST_LATCH) ? '0 : pix_idx_reg + PIX_W'(1);
    assign load_word = pixel_word[load_idx];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= ST_LATCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_LATCH: begin
                if (latch_cnt_reg == LAT_LAST) begin
                    state_next = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (phase_reg == (shift_reg[23] ? T1H_LAST : T0H_LAST)) begin
                    state_next = ST_LOW;
                end
            end
            ST_LOW: begin
                if (phase_reg == PH_LAST) begin
                    if ((bit_cnt_reg != 5'd0) || (pix_idx_reg != LAST_PIX)) begin
                        state_next = ST_HIGH;
                    end else begin
                        state_next = ST_LATCH;
                    end
                end
            end
            default: state_next = ST_LATCH;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // data and frame_done are computed from the next state and registered,
    // so they line up exactly with the state they describe.
    always_comb begin
        data_next       = (state_next == ST_HIGH);
        frame_done_next = (state_reg == ST_LOW) && (state_next == ST_LATCH);
        busy            = (state_reg != ST_LATCH);
    end

    assign data       = data_reg;
    assign frame_done = frame_done_reg;

    // ---------------- counters, shift register, output registers ----------------
    logic start_bit;
    assign start_bit = (state_next == ST_HIGH) && (state_reg != ST_HIGH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            latch_cnt_reg  <= '0;
            phase_reg      <= '0;
            bit_cnt_reg    <= '0;
            pix_idx_reg    <= '0;
            shift_reg      <= '0;
            data_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            data_reg       <= data_next;
            frame_done_reg <= frame_done_next;

            if ((state_reg == ST_LATCH) && (state_next == ST_LATCH)) begin
                latch_cnt_reg <= latch_cnt_reg + LAT_W'(1);
            end else begin
                latch_cnt_reg <= '0;
            end

            if (start_bit || (state_next == ST_LATCH)) begin
                phase_reg <= '0;
            end else begin
                phase_reg <= phase_reg + PH_W'(1);
            end

            if (start_bit) begin
                if ((state_reg == ST_LOW) && (bit_cnt_reg != 5'd0)) begin
                    shift_reg   <= {shift_reg[22:0], 1'b0};
                    bit_cnt_reg <= bit_cnt_reg - 5'd1;
                end else begin
                    // The store is read here, so a write landing on this same
                    // edge is seen only by the next frame.
                    shift_reg   <= load_word;
                    bit_cnt_reg <= 5'd23;
                    pix_idx_reg <= load_idx;
                end
            end
        end
    end

endmodule
